// File: rtl/program_sequencer.sv
// Program counter sequencer with a bounded LIFO return stack.
// One action per edge, priority stall > ret > call > jmp > sequential.
module program_sequencer #(
   parameter int unsigned AW         = 16,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned RESET_ADDR = 0,
   parameter int unsigned INC        = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall,
   input  logic                         jmp,
   input  logic                         abs,
   input  logic                         call,
   input  logic                         ret,
   input  logic [AW-1:0]                pc_write,
   output logic [AW-1:0]                pc_out,
   output logic [$clog2(DEPTH+1)-1:0]   sp,
   output logic                         stack_full,
   output logic                         stack_empty,
   output logic                         stack_err
);

   localparam int SPW = $clog2(DEPTH + 1);
   localparam int IW  = $clog2(DEPTH);

   logic [AW-1:0]  stack_mem [DEPTH];
   logic [AW-1:0]  seq_pc;
   logic [AW-1:0]  target;
   logic [AW-1:0]  next_pc;
   logic [SPW-1:0] next_sp;
   logic           push;
   logic           err_set;

   assign stack_full  = (sp == SPW'(DEPTH));
   assign stack_empty = (sp == SPW'(0));
   assign seq_pc      = pc_out + AW'(INC);
   assign target      = abs ? pc_write : (pc_out + pc_write);

   // Next-state selection; a failed call/ret still advances sequentially.
   always_comb begin
      next_pc = seq_pc;
      next_sp = sp;
      push    = 1'b0;
      err_set = 1'b0;
      if (stall) begin
         next_pc = pc_out;
      end else if (ret) begin
         if (stack_empty) begin
            err_set = 1'b1;
         end else begin
            next_pc = stack_mem[IW'(sp - SPW'(1))];
            next_sp = sp - SPW'(1);
         end
      end else if (call) begin
         if (stack_full) begin
            err_set = 1'b1;
         end else begin
            push    = 1'b1;
            next_pc = target;
            next_sp = sp + SPW'(1);
         end
      end else if (jmp) begin
         next_pc = target;
      end else begin
         next_pc = seq_pc;
      end
   end

   // PC, stack pointer and sticky error register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_out    <= AW'(RESET_ADDR);
         sp        <= SPW'(0);
         stack_err <= 1'b0;
      end else begin
         pc_out <= next_pc;
         sp     <= next_sp;
         if (err_set) begin
            stack_err <= 1'b1;
         end
      end
   end

   // Return-address storage; a write racing reset is dropped so no partial push.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         stack_mem[IW'(sp)] <= seq_pc;
      end
   end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: queue-based reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_program_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, jmp = 1'b0, abs = 1'b0, call = 1'b0, ret = 1'b0;
   logic [15:0] pc_write = 16'h0000;
   logic [15:0] pc_out;
   logic [2:0]  sp;
   logic        stack_full, stack_empty, stack_err;

   int n_tests = 0;
   int n_fail  = 0;

   program_sequencer #(.AW(16), .DEPTH(4), .RESET_ADDR(0), .INC(1)) dut (
      .clk(clk), .rst(rst), .stall(stall), .jmp(jmp), .abs(abs),
      .call(call), .ret(ret), .pc_write(pc_write), .pc_out(pc_out),
      .sp(sp), .stack_full(stack_full), .stack_empty(stack_empty),
      .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   // Reference model: return addresses in a queue, PC as plain 16-bit arithmetic.
   logic [15:0] m_pc = 16'h0000;
   logic [15:0] m_stack[$];
   logic        m_err = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc = 16'h0000;
         m_stack.delete();
         m_err = 1'b0;
      end else if (!stall) begin
         if (ret) begin
            if (m_stack.size() == 0) begin
               m_err = 1'b1;
               m_pc  = m_pc + 16'd1;
            end else begin
               m_pc = m_stack.pop_back();
            end
         end else if (call) begin
            if (m_stack.size() == 4) begin
               m_err = 1'b1;
               m_pc  = m_pc + 16'd1;
            end else begin
               m_stack.push_back(m_pc + 16'd1);
               m_pc = abs ? pc_write : m_pc + pc_write;
            end
         end else if (jmp) begin
            m_pc = abs ? pc_write : m_pc + pc_write;
         end else begin
            m_pc = m_pc + 16'd1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("model_pc", pc_out, m_pc);
         chk("model_sp", sp, m_stack.size());
         chk("model_full", stack_full, m_stack.size() == 4);
         chk("model_empty", stack_empty, m_stack.size() == 0);
         chk("model_err", stack_err, m_err);
      end
   end

   task automatic cyc(input logic s, input logic j, input logic a,
                      input logic c, input logic r, input logic [15:0] pw);
      stall = s; jmp = j; abs = a; call = c; ret = r; pc_write = pw;
      @(negedge clk);
      stall = 1'b0; jmp = 1'b0; abs = 1'b0; call = 1'b0; ret = 1'b0;
      pc_write = 16'h0000;
   endtask

   initial begin
      @(negedge clk);
      chk("reset_pc", pc_out, 16'h0000);
      chk("reset_sp", sp, 0);
      chk("reset_empty", stack_empty, 1);
      chk("reset_full", stack_full, 0);
      chk("reset_err", stack_err, 0);
      rst = 1'b0;

      // Sequential counting from reset
      for (int i = 1; i <= 5; i++) begin
         cyc(0, 0, 0, 0, 0, 16'h0000);
         chk("seq_pc", pc_out, i);
      end
      chk("seq_sp", sp, 0);

      // Absolute / relative jumps and wraparound
      cyc(0, 1, 1, 0, 0, 16'h0010);  chk("jmp_abs10", pc_out, 16'h0010);
      cyc(0, 1, 1, 0, 0, 16'h0100);  chk("jmp_abs100", pc_out, 16'h0100);
      cyc(0, 1, 0, 0, 0, 16'hFFFE);  chk("jmp_rel_neg", pc_out, 16'h00FE);
      cyc(0, 1, 1, 0, 0, 16'hFFFF);  chk("jmp_ffff", pc_out, 16'hFFFF);
      cyc(0, 0, 0, 0, 0, 16'h0000);  chk("seq_wrap", pc_out, 16'h0000);

      // Nested call / return
      cyc(0, 1, 1, 0, 0, 16'h0004);  chk("to_4", pc_out, 16'h0004);
      cyc(0, 0, 1, 1, 0, 16'h0040);  chk("call_abs_pc", pc_out, 16'h0040);
      chk("call_abs_sp", sp, 1);
      cyc(0, 0, 0, 0, 0, 16'h0000);  chk("at_41", pc_out, 16'h0041);
      cyc(0, 0, 0, 1, 0, 16'h0010);  chk("call_rel_pc", pc_out, 16'h0051);
      chk("call_rel_sp", sp, 2);
      cyc(0, 0, 0, 0, 1, 16'h0000);  chk("ret1_pc", pc_out, 16'h0042);
      chk("ret1_sp", sp, 1);
      cyc(0, 0, 0, 0, 1, 16'h0000);  chk("ret2_pc", pc_out, 16'h0005);
      chk("ret2_sp", sp, 0);

      // Stall freezes everything; call+ret pops only; jmp+call follows call
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 1, 0, 0, 16'h0999);
         chk("stall_pc", pc_out, 16'h0005);
      end
      cyc(0, 0, 1, 1, 0, 16'h0080);  chk("call80_pc", pc_out, 16'h0080);
      cyc(0, 0, 1, 1, 1, 16'h0500);  chk("callret_pc", pc_out, 16'h0006);
      chk("callret_sp", sp, 0);
      chk("callret_err", stack_err, 0);
      cyc(0, 1, 1, 1, 0, 16'h0200);  chk("jmpcall_pc", pc_out, 16'h0200);
      chk("jmpcall_sp", sp, 1);
      cyc(0, 0, 0, 0, 1, 16'h0000);  chk("jmpcall_ret", pc_out, 16'h0007);

      // Overflow then underflow
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0, 16'h0300);
      chk("full_sp", sp, 4);
      chk("full_flag", stack_full, 1);
      chk("full_noerr", stack_err, 0);
      cyc(0, 0, 1, 1, 0, 16'h0300);  chk("ovf_pc", pc_out, 16'h0301);
      chk("ovf_sp", sp, 4);
      chk("ovf_err", stack_err, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 16'h0000);
      chk("pop3_pc", pc_out, 16'h0301);
      cyc(0, 0, 0, 0, 1, 16'h0000);  chk("pop4_pc", pc_out, 16'h0008);
      chk("pop4_empty", stack_empty, 1);
      cyc(0, 0, 0, 0, 1, 16'h0000);  chk("unf_pc", pc_out, 16'h0009);
      chk("unf_sp", sp, 0);
      chk("unf_err", stack_err, 1);
      cyc(0, 0, 0, 0, 0, 16'h0000);  chk("err_sticky", stack_err, 1);
      chk("after_err_pc", pc_out, 16'h000A);

      // Asynchronous reset between edges while a call is pending
      cyc(0, 0, 1, 1, 0, 16'h0400);  chk("pre_rst_sp", sp, 1);
      call = 1'b1; abs = 1'b1; pc_write = 16'h0444;
      #2 rst = 1'b1;
      #1;
      chk("arst_pc", pc_out, 16'h0000);
      chk("arst_sp", sp, 0);
      chk("arst_err", stack_err, 0);
      chk("arst_empty", stack_empty, 1);
      @(negedge clk);
      chk("arst_hold_sp", sp, 0);
      call = 1'b0; abs = 1'b0; pc_write = 16'h0000;
      rst = 1'b0;
      cyc(0, 0, 0, 0, 0, 16'h0000);  chk("post_rst_pc", pc_out, 16'h0001);
      cyc(0, 0, 0, 0, 1, 16'h0000);  chk("post_rst_unf", pc_out, 16'h0002);
      chk("post_rst_err", stack_err, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter AW, default 16: width of all address buses.
REQ-002 Parameter DEPTH, default 4: return-stack entries; legal range 2..16.
REQ-003 Parameter RESET_ADDR, default 0: PC value loaded by reset.
REQ-004 Parameter INC, default 1: sequential increment step.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 stall  in  1  hold PC and stack unchanged this cycle.
REQ-008 jmp  in  1  jump request.
REQ-009 abs  in  1  jump/call mode: 1 = absolute target, 0 = PC-relative.
REQ-010 call  in  1  subroutine call: push return address, then jump per abs.
REQ-011 ret  in  1  return: pop stack into PC.
REQ-012 pc_write  in  AW  absolute target, or two's-complement offset when abs=0.
REQ-013 pc_out  out  AW  current program counter, registered.
REQ-014 sp  out  clog2(DEPTH+1)  number of valid stack entries.
REQ-015 stack_full  out  1  combinational: sp == DEPTH.
REQ-016 stack_empty  out  1  combinational: sp == 0.
REQ-017 stack_err  out  1  sticky overflow/underflow flag, registered.

Function
REQ-018 The block SHALL evaluate one action per rising edge, with priority stall > ret > call > jmp > sequential.
REQ-019 With stall=1, pc_out, sp, stack contents and stack_err SHALL hold.
REQ-020 Sequential: pc_out SHALL become pc_out + INC, modulo 2^AW.
REQ-021 jmp with abs=1: pc_out SHALL become pc_write.
REQ-022 jmp with abs=0: pc_out SHALL become pc_out + pc_write, modulo 2^AW; negative offsets wrap correctly.
REQ-023 call (not full): the block SHALL push pc_out + INC, increment sp, and load the target exactly as REQ-021/REQ-022 per abs.
REQ-024 ret (not empty): pc_out SHALL become the top entry and sp SHALL decrement.
REQ-025 call while stack_full: no push, sp unchanged, pc_out advances sequentially, stack_err set.
REQ-026 ret while stack_empty: sp unchanged, pc_out advances sequentially, stack_err set.
REQ-027 call and ret asserted together: ret SHALL win per REQ-018, and call SHALL be ignored without error.
REQ-028 jmp asserted together with call SHALL be ignored, since call already carries the target.
REQ-029 Latency: every action SHALL be visible on pc_out one cycle after the sampling edge, with no bubbles.
REQ-030 stack_err SHALL stay set once raised until reset, and SHALL not block normal operation.
REQ-031 The stack SHALL be LIFO; entries above sp are don't-care and never observable.

Reset
REQ-032 Asserting rst SHALL immediately, without waiting for clk, force pc_out=RESET_ADDR, sp=0, stack_err=0; stack_empty=1, stack_full=0.
REQ-033 rst asserted mid-call or mid-ret SHALL discard the operation with no partial push or pop.
REQ-034 On the first edge after rst deasserts, the block SHALL act on its inputs normally.
REQ-035 Stack RAM contents need not be reset.

Verification
REQ-036 Sequential: rst then release, all controls 0, 5 cycles -> pc_out 0,1,2,3,4,5; sp=0.
REQ-037 Jumps: pc_out=0x0010; jmp=1, abs=1, pc_write=0x0100 -> 0x0100; next jmp=1, abs=0, pc_write=0xFFFE -> 0x00FE; pc_out=0xFFFF sequential -> 0x0000.
REQ-038 Call/ret nesting: at pc 0x0004 call abs=1, pc_write=0x0040 -> pc 0x0040, sp=1; at 0x0041 call abs=0, pc_write=0x0010 -> pc 0x0051, sp=2; ret -> 0x0042, sp=1; ret -> 0x0005, sp=0.
REQ-039 Overflow/underflow: DEPTH=4, 5 calls -> sp=4, stack_full=1, stack_err=1, 5th call increments pc only; from sp=0 ret -> stack_err=1, pc+1.
REQ-040 Stall and priority: stall=1 with jmp=1 for 3 cycles -> pc_out and sp frozen; call=1 and ret=1 at sp=1 -> pop occurs, no push, sp=0.
REQ-041 Async reset: assert rst between clock edges mid-sequence -> pc_out=RESET_ADDR and sp=0 before the next edge; stack_err cleared.
